// File: rtl/osc_vector_sweeper.sv
// Exhaustive input-vector sweeper for a combinational-loop block: drives every
// vector, waits SETTLE cycles, samples the oscillation flag and records hits.
module osc_vector_sweeper #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             osc_flag_in,
  output logic [WIDTH-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   hit_count,
  output logic [WIDTH-1:0] first_hit,
  output logic [WIDTH-1:0] last_hit,
  output logic             hit_valid
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] settle_cnt;
  logic          last_vec;

  assign last_vec = (vec_out == '1);

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE:   if (start) state_n = S_SETTLE;
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == CW'(SETTLE - 1)) state_n = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy    = 1'b1;
        state_n = last_vec ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      vec_out    <= '0;
      settle_cnt <= '0;
      hit_count  <= '0;
      first_hit  <= '0;
      last_hit   <= '0;
      hit_valid  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (start) begin
            vec_out    <= '0;
            settle_cnt <= '0;
            hit_count  <= '0;
            first_hit  <= '0;
            last_hit   <= '0;
            hit_valid  <= 1'b0;
          end
        end
        S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
        S_SAMPLE: begin
          if (osc_flag_in) begin
            hit_count <= hit_count + 1'b1;
            last_hit  <= vec_out;
            if (!hit_valid) begin
              first_hit <= vec_out;
              hit_valid <= 1'b1;
            end
          end
          // The final vector is held on exit so vec_out never wraps to zero.
          if (!last_vec) begin
            vec_out    <= vec_out + 1'b1;
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_vector_sweeper.sv
// Scoreboarded bench for osc_vector_sweeper: two instances (SETTLE=2 and
// SETTLE=1) sharing clock/reset, selected per scenario.
module tb_osc_vector_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  int   mode = 0;

  logic [7:0] vec0, vec1, first0, first1, last0, last1;
  logic [8:0] cnt0, cnt1;
  logic       busy0, busy1, done0, done1, valid0, valid1;
  logic       flag0, flag1;

  logic [7:0] vec_s, first_s, last_s;
  logic [8:0] cnt_s;
  logic       busy_s, done_s, valid_s;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [8:0] cnt;
    logic [7:0] first;
    logic [7:0] last;
    logic       valid;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic bit in_set(input logic [7:0] v);
    case (v)
      8'h4C, 8'h55, 8'h61, 8'h7A, 8'h80, 8'h93,
      8'hA5, 8'hB7, 8'hC2, 8'hD9, 8'hEE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Stand-in for the live combLogic: flag is a combinational function of the vector
  assign flag0 = (mode == 0) ? in_set(vec0) : (mode == 2);

  always_ff @(posedge clk) flag1 <= (vec1 == 8'h05);

  osc_vector_sweeper #(.WIDTH(8), .SETTLE(2)) dut0 (
    .clk(clk), .rst(rst), .start(start && !sel), .osc_flag_in(flag0),
    .vec_out(vec0), .busy(busy0), .done(done0), .hit_count(cnt0),
    .first_hit(first0), .last_hit(last0), .hit_valid(valid0)
  );

  osc_vector_sweeper #(.WIDTH(8), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start && sel), .osc_flag_in(flag1),
    .vec_out(vec1), .busy(busy1), .done(done1), .hit_count(cnt1),
    .first_hit(first1), .last_hit(last1), .hit_valid(valid1)
  );

  assign vec_s   = sel ? vec1   : vec0;
  assign first_s = sel ? first1 : first0;
  assign last_s  = sel ? last1  : last0;
  assign cnt_s   = sel ? cnt1   : cnt0;
  assign busy_s  = sel ? busy1  : busy0;
  assign done_s  = sel ? done1  : done0;
  assign valid_s = sel ? valid1 : valid0;

  function automatic exp_t model(input int m);
    exp_t e;
    bit   f;
    e.cnt = '0; e.first = '0; e.last = '0; e.valid = 1'b0;
    for (int v = 0; v < 256; v++) begin
      if (m == 3)      f = (v == 5);
      else if (m == 0) f = in_set(8'(v));
      else             f = (m == 2);
      if (f) begin
        e.cnt++;
        e.last = 8'(v);
        if (!e.valid) begin e.first = 8'(v); e.valid = 1'b1; end
      end
    end
    e.lat = 256 * ((m == 3) ? 2 : 3) + 1;
    return e;
  endfunction

  task automatic sweep(input int m, input bit re40, input bit rs80, input bit b2b,
                       input string name);
    exp_t e;
    int   n, busy_n;
    bit   fired, aborted;
    mode = (m == 3) ? 1 : m;
    sb.push_back(model(m));
    n = 0; busy_n = 0; fired = 0; aborted = 0;
    @(negedge clk); start = 1'b1;
    forever begin
      @(negedge clk); start = 1'b0; n++;
      if (busy_s) busy_n++;
      if (re40 && !fired && vec_s == 8'h40) begin start = 1'b1; fired = 1'b1; end
      if (rs80 && vec_s == 8'h80) begin
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        total++;
        if ({vec_s, busy_s, done_s, cnt_s, first_s, last_s, valid_s} !== '0) begin
          bad++;
          $display("FAIL %s reset_values: got vec=%h busy=%b done=%b cnt=%h first=%h last=%h valid=%b want all 0",
                   name, vec_s, busy_s, done_s, cnt_s, first_s, last_s, valid_s);
        end
        aborted = 1'b1;
        break;
      end
      if (done_s) break;
      if (n > 3000) begin
        total++; bad++;
        $display("FAIL %s timeout: no done after %0d cycles", name, n);
        break;
      end
    end
    e = sb.pop_front();
    if (aborted) return;
    total++;
    if (n !== e.lat) begin bad++; $display("FAIL %s done_latency: got %0d want %0d", name, n, e.lat); end
    total++;
    if (busy_n !== e.lat) begin bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, e.lat); end
    total++;
    if (cnt_s !== e.cnt) begin bad++; $display("FAIL %s hit_count: got %h want %h", name, cnt_s, e.cnt); end
    total++;
    if (first_s !== e.first) begin bad++; $display("FAIL %s first_hit: got %h want %h", name, first_s, e.first); end
    total++;
    if (last_s !== e.last) begin bad++; $display("FAIL %s last_hit: got %h want %h", name, last_s, e.last); end
    total++;
    if (valid_s !== e.valid) begin bad++; $display("FAIL %s hit_valid: got %b want %b", name, valid_s, e.valid); end
    total++;
    if (vec_s !== 8'hFF) begin bad++; $display("FAIL %s final_vec: got %h want ff", name, vec_s); end
    if (b2b) start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++;
    if ({busy_s, done_s} !== 2'b00) begin
      bad++;
      $display("FAIL %s after_done: got busy=%b done=%b want 0 0", name, busy_s, done_s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({vec0, busy0, done0, cnt0, first0, last0, valid0} !== '0) begin
      bad++;
      $display("FAIL reset: got vec=%h busy=%b done=%b cnt=%h first=%h last=%h valid=%b want all 0",
               vec0, busy0, done0, cnt0, first0, last0, valid0);
    end
  endtask

  task automatic test_live();
    sweep(0, 1'b0, 1'b0, 1'b0, "live");
  endtask

  task automatic test_no_flags();
    sweep(1, 1'b0, 1'b0, 1'b0, "no_flags");
    mode = 2;
    repeat (10) @(negedge clk);
    total++;
    if ({cnt0, valid0, busy0} !== '0) begin
      bad++;
      $display("FAIL idle_hold: got cnt=%h valid=%b busy=%b want 0 0 0", cnt0, valid0, busy0);
    end
  endtask

  task automatic test_all_flags();
    sweep(2, 1'b0, 1'b0, 1'b0, "all_flags");
  endtask

  task automatic test_restart();
    sweep(0, 1'b1, 1'b0, 1'b0, "restart_ignored");
  endtask

  task automatic test_mid_reset();
    sweep(0, 1'b0, 1'b1, 1'b0, "mid_reset");
    sweep(0, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    sweep(0, 1'b0, 1'b0, 1'b1, "b2b_first");
    repeat (3) @(negedge clk);
    total++;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL b2b_not_seen: got busy=%b want 0", busy0); end
    sweep(1, 1'b0, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_settle1();
    sel = 1'b1;
    sweep(3, 1'b0, 1'b0, 1'b0, "settle1");
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_live();
    test_no_flags();
    test_all_flags();
    test_restart();
    test_mid_reset();
    test_back_to_back();
    test_settle1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/osc_vector_sweeper.md
Name: osc_vector_sweeper

Overview:
- Stimulus-and-capture stage placed directly upstream of combLogic.
- Sweeps every 2^WIDTH input vector onto combLogic's primary inputs, waits a programmable settle time, then samples combLogic's OscFlag.
- Reports the number of oscillation-flagged vectors and the first and last flagged vector codes.
- Gives a single-command exhaustive oscillation-condition scan of the combinational loop.

Parameters:
- WIDTH, 8: number of driven inputs. vec_out[0] drives w_003_001, ..., vec_out[7] drives w_003_008.
- SETTLE, 2: cycles a vector is held before OscFlag is sampled. Legal values are ≥1.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle request to begin a sweep. Honoured only in IDLE.
- osc_flag_in, input, 1: OscFlag from combLogic.
- vec_out, output, WIDTH: vector currently applied to combLogic.
- busy, output, 1: high from the cycle after start is accepted until DONE is exited.
- done, output, 1: one-cycle pulse when the sweep completes.
- hit_count, output, WIDTH+1: number of vectors sampled with osc_flag_in=1.
- first_hit, output, WIDTH: lowest flagged vector code.
- last_hit, output, WIDTH: highest flagged vector code.
- hit_valid, output, 1: at least one flagged vector found.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE.
  - vec_out=0, busy=0, done=0, hit_count=0, first_hit=0, last_hit=0, hit_valid=0.
  - settle counter=0.
  - rst overrides start and any in-progress sweep; a mid-sweep reset abandons the sweep and discards partial results.
- State machine: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If start=1: clear hit_count, first_hit, last_hit and hit_valid; set vec_out=0 and settle counter=0; go to SETTLE; busy=1 from the next cycle.
  - If start=0: hold all outputs. Previous results remain readable.
- SETTLE:
  - Increment the settle counter each cycle.
  - When the counter equals SETTLE-1, go to SAMPLE.
  - vec_out is stable throughout.
- SAMPLE (one cycle):
  - Register osc_flag_in.
  - If it is 1: hit_count += 1; last_hit = vec_out; if hit_valid=0, also set first_hit = vec_out and hit_valid = 1.
  - If vec_out = 2^WIDTH-1, go to DONE with no wrap of vec_out.
  - Otherwise vec_out += 1, settle counter = 0, go to SETTLE.
- DONE (one cycle): done=1, busy stays 1; next state IDLE, where busy=0 and done=0.
- Timing:
  - Each vector occupies exactly SETTLE+1 cycles.
  - The first sample is taken SETTLE+1 cycles after the start edge.
  - Total busy duration is 2^WIDTH × (SETTLE+1) + 1 cycles.
- Arithmetic and widths:
  - hit_count is WIDTH+1 bits so that an all-flagged sweep (2^WIDTH hits) does not overflow.
  - vec_out increments unsigned and never wraps within a sweep.
- Boundary conditions:
  - start while busy (SETTLE, SAMPLE or DONE) is ignored, with no restart and no queueing.
  - start in the same cycle that DONE returns to IDLE is not seen. The next start in IDLE is accepted.
  - osc_flag_in is ignored outside SAMPLE.
  - With no flagged vectors: hit_valid=0, first_hit=0, last_hit=0, hit_count=0.
- Results hold until the next accepted start or reset.

Test Plan:
- Full sweep against a live combLogic with SETTLE=2, start pulsed once:
  - done asserts 769 cycles after the start edge (256×3 + 1).
  - hit_count=11, first_hit=0x4C, last_hit=0xEE, hit_valid=1.
- osc_flag_in tied to 0 for a full sweep: hit_count=0, hit_valid=0, first_hit=0, last_hit=0, done pulses exactly once.
- osc_flag_in tied to 1: hit_count=256 (0x100, with no overflow to 0), first_hit=0x00, last_hit=0xFF.
- start re-pulsed at vector 0x40 mid-sweep: the sweep continues unaffected and the final results are identical to the first scenario.
- rst asserted for one cycle while vec_out=0x80, then start pulsed:
  - the cycle after rst shows all outputs at their reset values;
  - the new sweep completes with the first-scenario results.
- SETTLE=1 with osc_flag_in a registered copy of (vec_out==0x05):
  - the sample is taken on the cycle vec_out=0x05 has been held 1 cycle;
  - hit_count=1, first_hit=last_hit=0x05;
  - total busy duration is 513 cycles.
